uart_rx: RTL and testbench

//   8N1 UART receiver: the receive counterpart of the board's uart_tx. Samples the

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchroniser, mid-bit sampling and a valid/ready byte output.
// Latency: valid rises on the mid-stop-bit sample edge, about 9.5 bit times + 3 clk after the start edge.
// Backpressure: one-byte holding register. A byte completing while valid&!ready is dropped and pulses overrun.
// Optional: define UART_RX_PARITY_EN for 8E1 framing, which enables the PARITY state and the parity_err pulse.
module uart_rx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Too few ticks per bit leaves no room for a mid-bit sample point.
    generate
        if (BIT_TICKS < 4) begin : g_bad_cfg
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic             rx_meta;
    logic             rx_s;
    logic             rx_d;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             stop_tick;
    logic             stop_bad;
    logic             par_bad;
    logic             done_ok;

`ifdef UART_RX_PARITY_EN
    logic             par_bit;
`endif

    // Two-flop synchroniser onto clk, plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Decode the stop-bit sample point: good byte, framing error, or parity error.
    assign stop_tick = (state == STOP) && (cnt == BIT_LAST);
    assign stop_bad  = stop_tick && !rx_s;
`ifdef UART_RX_PARITY_EN
    assign par_bad   = stop_tick && rx_s && (par_bit != ^shift);
`else
    assign par_bad   = 1'b0;
`endif
    assign done_ok   = stop_tick && rx_s && !par_bad;

    // Frame FSM: tick counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame; a held-low break never retriggers.
                    if (rx_d && !rx_s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid-start means a glitch, not a start bit.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a start edge right after the stop bit is still seen.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output holding register, handshake and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= stop_bad;
            parity_err <= par_bad;
            overrun    <= 1'b0;
            if (done_ok) begin
                // A same-cycle accept frees the register, so the new byte loads without overrun.
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_TICKS=16: directed frames, with expected bytes and error events queued by the
// driver and consumed by an independent monitor that samples DUT outputs on the falling clock edge.
// Inputs change 2 time units after the rising edge, so they are stable whenever the monitor samples.
module tb_uart_rx;

    localparam int BT = 16;

    localparam int K_FRAME  = 1;
    localparam int K_OVERUN = 2;
    localparam int K_PARITY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] byte_q[$];
    int         err_q[$];

    uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic err_seen(input string name, input int kind);
        if (err_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got unexpected pulse expected none", name);
        end else begin
            check(name, kind, err_q.pop_front());
        end
    endtask

    // Monitor: every error pulse cycle and every accepted byte consumes one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)  err_seen("frame_err", K_FRAME);
            if (overrun)    err_seen("overrun", K_OVERUN);
            if (parity_err) err_seen("parity_err", K_PARITY);
            if (valid && ready) begin
                if (byte_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte: got unexpected %0h expected none", data);
                end else begin
                    check("byte", data, byte_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BT) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();

        // 1: ready high, single good byte
        byte_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (4) tick();
        check("t1_valid_dropped", valid, 1'b0);

        // 2: stop bit low -> frame error, data keeps 0x55; next byte still fine
        err_q.push_back(K_FRAME);
        send_frame(8'hA3, 1'b0, 1'b0);
        check("t2_valid", valid, 1'b0);
        check("t2_data_kept", data, 8'h55);
        byte_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);

        // 3: short low glitch -> false start, nothing reported
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3 * BT) tick();
        check("t3_valid", valid, 1'b0);
        check("t3_data", data, 8'h01);

        // 4: ready low, two bytes -> second overruns, first delivered on ready
        ready = 1'b0;
        byte_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        check("t4_valid_held", valid, 1'b1);
        check("t4_data_first", data, 8'h12);
        err_q.push_back(K_OVERUN);
        send_frame(8'h34, 1'b1, 1'b0);
        check("t4_data_kept", data, 8'h12);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_cleared", valid, 1'b0);
        #1;
        repeat (8) tick();

        // 5: async reset in data bit 4 clears outputs with no clock edge
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx = 1'b0;
        repeat (8) tick();
        #1 rst = 1'b1;
        #1;
        check("t5_rst_data", data, 8'h00);
        check("t5_rst_valid", valid, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        rx = 1'b1;
        repeat (3 * BT) tick();
        byte_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good, then bad parity bit
        byte_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        err_q.push_back(K_PARITY);
        send_frame(8'h0F, 1'b1, 1'b1);
        check("t6_valid", valid, 1'b0);
`endif

        repeat (2 * BT) tick();
        check("bytes_pending", byte_q.size(), 0);
        check("errors_pending", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
